regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-register file with two async read ports, one write port, and a
//  per-register busy scoreboard for the pipelined datapath.
//  - Decode reserves a destination register; writeback writes and releases it.
//  - Readers see data plus a busy flag so the hazard unit can stall.
//  - Optional write-to-read bypass and hardwired-zero register 0.
// PARAMETERS
//  DATA_W    8  data word width in bits
//  ADDR_W    2  register address width; NREGS = 2**ADDR_W
//  ZERO_REG  0  1: reg 0 always reads 0, ignores writes and reserves
//  BYPASS    1  1: same-cycle write data forwarded to matching read port
// PORTS
//  clk       in   1          rising-edge clock, single domain
//  rst       in   1          synchronous, active-high reset
//  we        in   1          write enable (writeback)
//  waddr     in   ADDR_W     write register index
//  wdata     in   DATA_W     write data
//  rsv_en    in   1          reserve enable (decode/issue)
//  rsv_addr  in   ADDR_W     register to mark busy
//  ra1       in   ADDR_W     read port 1 index
//  rd1       out  DATA_W     read port 1 data
//  busy1     out  1          read port 1 register pending
//  ra2       in   ADDR_W     read port 2 index
//  rd2       out  DATA_W     read port 2 data
//  busy2     out  1          read port 2 register pending
//  busy_vec  out  NREGS      all busy bits, bit i = reg i
// BEHAVIOUR
//  - Reset: at a clk edge with rst=1, all regs <= 0 and busy_vec <= 0.
//    rst overrides same-cycle we/rsv_en. After reset: rd1=rd2=0, busy1=busy2=0.
//  - Write: at a clk edge with we=1, regs[waddr] <= wdata. Array visible next cycle.
//  - Write clears the busy bit of waddr in the same edge.
//  - Reserve: at a clk edge with rsv_en=1, busy[rsv_addr] <= 1. Visible next cycle.
//  - Reserve and write to the same register in the same cycle: busy ends 1
//    (the new producer wins). Data is still written.
//  - Reserve and write to different registers: both take effect.
//  - Write to a non-busy register is legal; busy stays 0.
//  - Re-reserving an already-busy register is legal; busy stays 1.
//  - Reads are combinational from ra1/ra2.
//    - BYPASS=1 and we && waddr==raN: rdN = wdata and busyN = 0.
//    - Otherwise: rdN = regs[raN] and busyN = busy[raN].
//    - BYPASS=0: no forwarding; the written value appears on the cycle after the edge.
//  - Both ports may read the same register; both get identical data.
//  - ZERO_REG=1:
//    - Writes and reserves to reg 0 are dropped; busy[0] is constant 0.
//    - ra==0 returns 0 and busyN=0, including under bypass.
//  - No X on outputs after first reset; every index 0..NREGS-1 is valid (no out-of-range).
// STRUCTURE
//  - regfile_defs.vh: NREGS derivation macro and reset data constant (all zeros).
//  - Sub-module regfile_scoreboard (clk, rst, set_en/set_addr, clr_en/clr_addr,
//    busy_vec). Set beats clear on the same index.
//  - Top level holds the data array, read muxes, bypass and zero-reg logic.
//  - Read-mux and bypass logic per port is generated from a single function;
//    no copy-paste per port.
// TESTING
//  1. Reset then read all regs, both ports -> every rd=0, busy_vec=0; repeat reset
//     mid-stream after writes -> all zero again.
//  2. Write reg2=8'hA5 (we=1), next cycle ra1=2 -> rd1=A5, busy1=0.
//     Same cycle ra2=2 with BYPASS=1 -> rd2=A5; with BYPASS=0 -> old value.
//  3. rsv_en reg3 -> next cycle busy_vec=4'b1000, busy for ra=3 is 1.
//     Write reg3=8'h3C -> next cycle busy=0, rd=3C.
//  4. Same cycle: rsv_en reg1 and we reg1=8'h11 -> next cycle busy_vec[1]=1, rd=11.
//     Reserve reg1 and write reg2 together -> busy_vec=4'b0010, reg2 updated.
//  5. ZERO_REG=1: write reg0=8'hFF and reserve reg0 -> rd=0, busy_vec[0]=0,
//     also during the bypass cycle.
//  6. DATA_W=16, ADDR_W=4: write i*16'h0101 to each of the 16 regs, read back
//     on both ports -> exact match; random we/rsv_en traffic checked vs reference model.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared types, constants and helpers for the register file
package regfile_sb_pkg;

  // Data value loaded into every register on reset, sliced to DATA_W by users.
  localparam logic [63:0] RST_WORD = '0;

  typedef enum logic [1:0] {
    SRC_ARRAY  = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_ZERO   = 2'd2
  } rd_src_e;

  function automatic int nregs(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Hardwired zero outranks forwarding, which outranks the stored array value.
  function automatic rd_src_e rd_src(input bit zero_reg, input bit bypass,
                                     input bit hit, input bit ra_zero);
    if (zero_reg && ra_zero) return SRC_ZERO;
    if (bypass && hit) return SRC_BYPASS;
    return SRC_ARRAY;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - write/reserve/read bus between datapath and register file
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) ();
  localparam int NREGS = nregs(ADDR_W);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] ra1;
  logic [DATA_W-1:0] rd1;
  logic              busy1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd2;
  logic              busy2;
  logic [NREGS-1:0]  busy_vec;

  modport master (
    output we, waddr, wdata, rsv_en, rsv_addr, ra1, ra2,
    input  rd1, busy1, rd2, busy2, busy_vec
  );

  modport slave (
    input  we, waddr, wdata, rsv_en, rsv_addr, ra1, ra2,
    output rd1, busy1, rd2, busy2, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits, set on reserve and cleared on writeback
module regfile_scoreboard #(
  parameter int NREGS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [NREGS-1:0]  busy_vec
);
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Set applied after clear so a new producer wins over a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with two async read ports, write bypass and busy scoreboard
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int NREGS = nregs(ADDR_W);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_vec;
  logic              wr_ok;
  logic              rsv_ok;
  logic              we_w;
  logic [ADDR_W-1:0] waddr_w;
  logic [DATA_W-1:0] wdata_w;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W:0]   rp [2];

  assign we_w    = bus.we;
  assign waddr_w = bus.waddr;
  assign wdata_w = bus.wdata;

  // With a hardwired zero register, traffic to index 0 never reaches storage.
  assign wr_ok  = bus.we && !(ZERO_REG && bus.waddr == '0);
  assign rsv_ok = bus.rsv_en && !(ZERO_REG && bus.rsv_addr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= DATA_W'(RST_WORD);
    end else if (wr_ok) begin
      regs_q[waddr_w] <= wdata_w;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .ADDR_W(ADDR_W)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (rsv_ok),
    .set_addr(bus.rsv_addr),
    .clr_en  (wr_ok),
    .clr_addr(waddr_w),
    .busy_vec(busy_vec)
  );

  // Returns {busy, data} for one read port.
  function automatic logic [DATA_W:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              wen,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] arr_data,
    input logic              arr_busy
  );
    case (rd_src(ZERO_REG, BYPASS, wen && (wa == addr), addr == '0))
      SRC_ZERO:   read_port = '0;
      SRC_BYPASS: read_port = {1'b0, wd};
      default:    read_port = {arr_busy, arr_data};
    endcase
  endfunction

  assign ra[0] = bus.ra1;
  assign ra[1] = bus.ra2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    assign rp[p] = read_port(ra[p], we_w, waddr_w, wdata_w, regs_q[ra[p]], busy_vec[ra[p]]);
  end

  assign bus.rd1      = rp[0][DATA_W-1:0];
  assign bus.busy1    = rp[0][DATA_W];
  assign bus.rd2      = rp[1][DATA_W-1:0];
  assign bus.busy2    = rp[1][DATA_W];
  assign bus.busy_vec = busy_vec;
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - bench for two register file configurations against a behavioural model
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: 8-bit, 4 regs, bypass on. Instance 1: 16-bit, 16 regs, zero reg, no bypass.
  localparam bit [1:0] ZRV = 2'b10;
  localparam bit [1:0] BPV = 2'b01;

  regfile_sb_if #(.DATA_W(8),  .ADDR_W(2)) ifa ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(4)) ifb ();

  regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  bit          s_we [2];
  bit          s_rsv[2];
  int          s_wa [2];
  int          s_rsa[2];
  int          s_ra1[2];
  int          s_ra2[2];
  logic [15:0] s_wd [2];

  assign ifa.we = s_we[0];  assign ifa.waddr = s_wa[0][1:0];  assign ifa.wdata = s_wd[0][7:0];
  assign ifa.rsv_en = s_rsv[0];  assign ifa.rsv_addr = s_rsa[0][1:0];
  assign ifa.ra1 = s_ra1[0][1:0];  assign ifa.ra2 = s_ra2[0][1:0];
  assign ifb.we = s_we[1];  assign ifb.waddr = s_wa[1][3:0];  assign ifb.wdata = s_wd[1];
  assign ifb.rsv_en = s_rsv[1];  assign ifb.rsv_addr = s_rsa[1][3:0];
  assign ifb.ra1 = s_ra1[1][3:0];  assign ifb.ra2 = s_ra2[1][3:0];

  logic [15:0] a_rd1[2], a_rd2[2], a_bv[2];
  logic        a_b1[2], a_b2[2];
  assign a_rd1[0] = {8'h00, ifa.rd1};  assign a_rd2[0] = {8'h00, ifa.rd2};
  assign a_rd1[1] = ifb.rd1;           assign a_rd2[1] = ifb.rd2;
  assign a_b1[0] = ifa.busy1;  assign a_b2[0] = ifa.busy2;
  assign a_b1[1] = ifb.busy1;  assign a_b2[1] = ifb.busy2;
  assign a_bv[0] = {12'h000, ifa.busy_vec};
  assign a_bv[1] = ifb.busy_vec;

  int vectors = 0;
  int fails = 0;
  bit ready = 1'b0;

  logic [15:0] m_reg [2][16];
  bit          m_busy[2][16];

  function automatic int nr(input int k);
    return (k == 0) ? 4 : 16;
  endfunction

  function automatic logic [15:0] msk(input int k);
    return (k == 0) ? 16'h00FF : 16'hFFFF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: arrays of values and busy flags updated by the architectural rules.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) begin
          m_reg[k][i]  <= 16'h0000;
          m_busy[k][i] <= 1'b0;
        end
      end else begin
        if (s_we[k] && !(ZRV[k] && s_wa[k] == 0)) begin
          m_reg[k][s_wa[k]]  <= s_wd[k] & msk(k);
          m_busy[k][s_wa[k]] <= 1'b0;
        end
        if (s_rsv[k] && !(ZRV[k] && s_rsa[k] == 0)) m_busy[k][s_rsa[k]] <= 1'b1;
      end
    end
    if (rst) ready <= 1'b1;
  end

  function automatic logic [16:0] exp_rd(input int k, input int ra);
    if (ZRV[k] && ra == 0) return 17'h0;
    if (BPV[k] && s_we[k] && s_wa[k] == ra) return {1'b0, s_wd[k] & msk(k)};
    return {m_busy[k][ra], m_reg[k][ra]};
  endfunction

  always @(negedge clk) begin : cmp
    logic [16:0] e1, e2;
    logic [15:0] ebv;
    if (ready) begin
      for (int k = 0; k < 2; k++) begin
        e1 = exp_rd(k, s_ra1[k]);
        e2 = exp_rd(k, s_ra2[k]);
        ebv = '0;
        for (int i = 0; i < nr(k); i++) ebv[i] = m_busy[k][i];
        chk($sformatf("m%0d_rd1", k), {16'h0, a_rd1[k]}, {16'h0, e1[15:0]});
        chk($sformatf("m%0d_busy1", k), {31'h0, a_b1[k]}, {31'h0, e1[16]});
        chk($sformatf("m%0d_rd2", k), {16'h0, a_rd2[k]}, {16'h0, e2[15:0]});
        chk($sformatf("m%0d_busy2", k), {31'h0, a_b2[k]}, {31'h0, e2[16]});
        chk($sformatf("m%0d_busy_vec", k), {16'h0, a_bv[k]}, {16'h0, ebv});
      end
    end
  end

  task automatic drv(input int k, input bit we, input int wa, input int wd,
                     input bit rs, input int rsa, input int r1, input int r2);
    s_we[k] = we;  s_wa[k] = wa;  s_wd[k] = wd[15:0] & msk(k);
    s_rsv[k] = rs; s_rsa[k] = rsa; s_ra1[k] = r1; s_ra2[k] = r2;
  endtask

  task automatic both(input bit we, input int wa, input int wd,
                      input bit rs, input int rsa, input int r1, input int r2);
    drv(0, we, wa, wd, rs, rsa, r1, r2);
    drv(1, we, wa, wd, rs, rsa, r1, r2);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    both(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    for (int r = 0; r < 4; r++) begin
      drv(0, 0, 0, 0, 0, 0, r, 3 - r);
      drv(1, 0, 0, 0, 0, 0, r, 15 - r);
      @(negedge clk);
      chk("rst_rd1", a_rd1[0], 0);
      chk("rst_rd2", a_rd2[0], 0);
      chk("rst_bv_a", a_bv[0], 0);
      chk("rst_bv_b", a_bv[1], 0);
      step();
    end

    both(1, 2, 'hA5, 0, 0, 2, 2);
    @(negedge clk);
    chk("bypass_on_rd2", a_rd2[0], 'hA5);
    chk("bypass_on_busy2", a_b2[0], 0);
    chk("bypass_off_rd2", a_rd2[1], 0);
    step();
    both(0, 0, 0, 0, 0, 2, 0);
    @(negedge clk);
    chk("wr_rd1_a", a_rd1[0], 'hA5);
    chk("wr_rd1_b", a_rd1[1], 'hA5);
    step();

    both(0, 0, 0, 1, 3, 3, 3);
    step();
    both(0, 0, 0, 0, 0, 3, 3);
    @(negedge clk);
    chk("rsv_bv_a", a_bv[0], 4'b1000);
    chk("rsv_busy1_a", a_b1[0], 1);
    chk("rsv_bv_b", a_bv[1], 16'h0008);
    step();
    both(1, 3, 'h3C, 0, 0, 0, 0);
    step();
    both(0, 0, 0, 0, 0, 3, 3);
    @(negedge clk);
    chk("release_bv_a", a_bv[0], 0);
    chk("release_rd1_a", a_rd1[0], 'h3C);
    chk("release_rd1_b", a_rd1[1], 'h3C);
    step();

    both(1, 1, 'h11, 1, 1, 1, 1);
    step();
    both(0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    chk("same_bv_a", a_bv[0], 4'b0010);
    chk("same_rd1_a", a_rd1[0], 'h11);
    chk("same_busy1_a", a_b1[0], 1);
    step();
    both(1, 2, 'h77, 1, 1, 0, 2);
    step();
    both(0, 0, 0, 0, 0, 1, 2);
    @(negedge clk);
    chk("diff_bv_a", a_bv[0], 4'b0010);
    chk("diff_rd2_a", a_rd2[0], 'h77);
    chk("diff_bv_b", a_bv[1], 16'h0002);
    step();

    drv(0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 'hFFFF, 1, 0, 0, 0);
    @(negedge clk);
    chk("zero_wr_rd1", a_rd1[1], 0);
    chk("zero_wr_busy1", a_b1[1], 0);
    step();
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("zero_after_bv", a_bv[1], 16'h0002);
    chk("zero_after_rd1", a_rd1[1], 0);
    step();

    rst = 1'b1;
    both(1, 2, 'h55, 1, 2, 0, 0);
    step();
    rst = 1'b0;
    both(0, 0, 0, 0, 0, 2, 1);
    @(negedge clk);
    chk("mid_rst_rd1", a_rd1[0], 0);
    chk("mid_rst_bv_a", a_bv[0], 0);
    chk("mid_rst_bv_b", a_bv[1], 0);
    step();

    for (int i = 0; i < 16; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      drv(1, 1, i, i * 'h0101, 0, 0, 0, 0);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      drv(1, 0, 0, 0, 0, 0, i, 15 - i);
      @(negedge clk);
      chk("wide_rd1", a_rd1[1], (i == 0) ? 0 : i * 'h0101);
      chk("wide_rd2", a_rd2[1], (i == 15) ? 0 : (15 - i) * 'h0101);
      step();
    end

    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(63) == 0);
      for (int k = 0; k < 2; k++) begin
        drv(k, 1'($urandom_range(1)), $urandom_range(nr(k) - 1), int'($urandom_range(65535)),
            1'($urandom_range(1)), $urandom_range(nr(k) - 1),
            $urandom_range(nr(k) - 1), $urandom_range(nr(k) - 1));
      end
      step();
    end

    rst = 1'b0;
    both(0, 0, 0, 0, 0, 0, 0);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
